// File: rtl/sysid_regs.sv
// sysid_regs: system-identification / build-info register bank on an Avalon-MM slave.
// Latency: reads return data READ_LATENCY cycles after accept; writes take effect at the accept edge.
// Backpressure: none; every read and write is accepted; a read wins over a simultaneous write.
//
// Ports:
//   clock          system clock, rising edge
//   reset_n        synchronous active-low reset
//   address[2:0]   word address
//   read, write    access strobes (no waitrequest)
//   writedata[31:0], byteenable[3:0]  write payload and lane enables
//   readdata[31:0] read data, zero unless readdatavalid
//   readdatavalid  one-cycle pulse per accepted read
//   tick           one-cycle pulse following each uptime increment
module sysid_regs #(
  parameter logic [31:0] SYS_ID       = 32'h5306_0A9D,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter logic [31:0] VERSION      = 32'h0001_0000,
  parameter logic [31:0] SCRATCH_RST  = 32'h0000_0000,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        tick
);

  // Depth of the read pipeline, held to the supported 1..3 range.
  localparam int unsigned RL = (READ_LATENCY < 1) ? 1 :
                               ((READ_LATENCY > 3) ? 3 : READ_LATENCY);

  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);
  localparam logic [31:0] CAPS_WORD = {24'(TICK_DIV), 2'b00, 2'(READ_LATENCY), 4'h1};

  localparam logic [2:0] A_SYSID   = 3'd0;
  localparam logic [2:0] A_TSTAMP  = 3'd1;
  localparam logic [2:0] A_VERSION = 3'd2;
  localparam logic [2:0] A_SCRATCH = 3'd3;
  localparam logic [2:0] A_UP_LO   = 3'd4;
  localparam logic [2:0] A_UP_HI   = 3'd5;
  localparam logic [2:0] A_CAPS    = 3'd6;
  localparam logic [2:0] A_CONTROL = 3'd7;

  // State
  logic [31:0]          scratch_q,   scratch_d;
  logic [23:0]          prescaler_q, prescaler_d;
  logic [63:0]          uptime_q,    uptime_d;
  logic [31:0]          shadow_hi_q, shadow_hi_d;
  logic                 tick_q,      tick_d;
  logic [RL-1:0]        rd_vld_q,    rd_vld_d;
  logic [RL-1:0][31:0]  rd_dat_q,    rd_dat_d;

  // Decoded bus controls
  logic        wr_en;
  logic        scratch_wr;
  logic        ctrl_clr;
  logic        lo_snap;
  logic        wrap;
  logic [31:0] rd_mux;

  // A read in the same cycle as a write drops the write.
  assign wr_en      = write & ~read;
  assign scratch_wr = wr_en && (address == A_SCRATCH);
  assign ctrl_clr   = wr_en && (address == A_CONTROL) && byteenable[0] && writedata[0];
  assign lo_snap    = read && (address == A_UP_LO);
  assign wrap       = (prescaler_q == TICK_LAST);

  // Read data is sampled from pre-edge register values in the accept cycle.
  always_comb begin
    rd_mux = 32'h0;
    case (address)
      A_SYSID:   rd_mux = SYS_ID;
      A_TSTAMP:  rd_mux = TIMESTAMP;
      A_VERSION: rd_mux = VERSION;
      A_SCRATCH: rd_mux = scratch_q;
      A_UP_LO:   rd_mux = uptime_q[31:0];
      A_UP_HI:   rd_mux = shadow_hi_q;
      A_CAPS:    rd_mux = CAPS_WORD;
      A_CONTROL: rd_mux = 32'h0;
      default:   rd_mux = 32'h0;
    endcase
  end

  // Read pipeline: stage 0 captures at the accept edge, last stage drives the bus.
  // Data is zeroed on idle slots so readdata is 0 whenever readdatavalid is low.
  always_comb begin
    rd_vld_d    = '0;
    rd_dat_d    = '0;
    rd_vld_d[0] = read;
    rd_dat_d[0] = read ? rd_mux : 32'h0;
    for (int s = 1; s < RL; s++) begin
      rd_vld_d[s] = rd_vld_q[s-1];
      rd_dat_d[s] = rd_dat_q[s-1];
    end
  end

  // Scratch register with per-lane byte enables.
  always_comb begin
    scratch_d = scratch_q;
    for (int b = 0; b < 4; b++) begin
      if (scratch_wr && byteenable[b]) begin
        scratch_d[8*b +: 8] = writedata[8*b +: 8];
      end
    end
  end

  // Uptime prescaler and counter. A CONTROL clear overrides a coincident
  // wrap, suppressing that tick as well.
  always_comb begin
    prescaler_d = wrap ? 24'd0 : (prescaler_q + 24'd1);
    uptime_d    = wrap ? (uptime_q + 64'd1) : uptime_q;
    tick_d      = wrap;
    if (ctrl_clr) begin
      prescaler_d = 24'd0;
      uptime_d    = 64'd0;
      tick_d      = 1'b0;
    end
  end

  // A low-word read latches the high word seen in the same cycle, so the
  // following high-word read pairs coherently even across a carry.
  always_comb begin
    shadow_hi_d = shadow_hi_q;
    if (lo_snap) begin
      shadow_hi_d = uptime_q[63:32];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      scratch_q   <= SCRATCH_RST;
      prescaler_q <= 24'd0;
      uptime_q    <= 64'd0;
      shadow_hi_q <= 32'h0;
      tick_q      <= 1'b0;
      rd_vld_q    <= '0;
      rd_dat_q    <= '0;
    end else begin
      scratch_q   <= scratch_d;
      prescaler_q <= prescaler_d;
      uptime_q    <= uptime_d;
      shadow_hi_q <= shadow_hi_d;
      tick_q      <= tick_d;
      rd_vld_q    <= rd_vld_d;
      rd_dat_q    <= rd_dat_d;
    end
  end

  assign readdata      = rd_dat_q[RL-1];
  assign readdatavalid = rd_vld_q[RL-1];
  assign tick          = tick_q;

endmodule

// File: tb/tb_sysid_regs.sv
// tb_sysid_regs: directed checks of sysid_regs.
// dut0: default divider, READ_LATENCY=2 (register map, scratch, read/write collision, reset discard).
// dut1: TICK_DIV=4, READ_LATENCY=1 (tick cadence, uptime snapshot coherence, clear vs wrap).
module tb_sysid_regs;

  localparam logic [31:0] TS   = 32'h6512_3456;
  localparam logic [31:0] SRST = 32'hA5A5_0F0F;
  localparam logic [31:0] SID  = 32'h5306_0A9D;
  localparam logic [31:0] VER  = 32'h0001_0000;
  // {24'd50000, 2'b00, 2'd2, 4'h1}
  localparam logic [31:0] CAPS0 = 32'h00C3_5021;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'h0;
  logic [3:0]  byteenable = 4'h0;

  logic [31:0] readdata0, readdata1;
  logic        rdv0, rdv1;
  logic        tick0, tick1;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  sysid_regs #(
    .TIMESTAMP(TS), .SCRATCH_RST(SRST), .READ_LATENCY(2)
  ) dut0 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata0), .readdatavalid(rdv0), .tick(tick0)
  );

  sysid_regs #(
    .TIMESTAMP(TS), .SCRATCH_RST(SRST), .TICK_DIV(4), .READ_LATENCY(1)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata1), .readdatavalid(rdv1), .tick(tick1)
  );

  typedef struct {
    logic        rstn;
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        exp_vld;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rstn, input logic rd, input logic wr,
                              input logic [2:0] addr, input logic [31:0] wd,
                              input logic [3:0] be, input logic ev, input logic [31:0] ed);
    vec_t v;
    v.rstn = rstn; v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.be = be;
    v.exp_vld = ev; v.exp_dat = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    read = 1'b0; write = 1'b0; address = 3'd0; writedata = 32'h0; byteenable = 4'h0;
  endtask

  initial begin
    int cnt, first, last, width_err, space_err;
    logic prev;

    // Each row is applied for one edge; its expectation is dut0's output right
    // after that edge. With READ_LATENCY=2 a read in row k shows up in row k+1.
    //                  rstn  rd    wr    addr  wd            be     vld   dat
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        4'h0, 1'b0, 32'h0));      // 0 reset
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        4'h0, 1'b0, 32'h0));      // 1
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 3'd0, 32'h0,        4'h0, 1'b0, 32'h0));      // 2 rd SYS_ID
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 3'd1, 32'h0,        4'h0, 1'b1, SID));        // 3 rd TS
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 3'd2, 32'h0,        4'h0, 1'b1, TS));         // 4 rd VER
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 3'd6, 32'h0,        4'h0, 1'b1, VER));        // 5 rd CAPS
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        4'h0, 1'b1, CAPS0));      // 6
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        4'h0, 1'b0, 32'h0));      // 7
    vq.push_back(mk(1'b1, 1'b0, 1'b1, 3'd3, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0));      // 8 wr scratch
    vq.push_back(mk(1'b1, 1'b0, 1'b1, 3'd3, 32'h00000012, 4'h1, 1'b0, 32'h0));      // 9 lane 0 only
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 3'd3, 32'h0,        4'h0, 1'b0, 32'h0));      // 10 rd scratch
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 32'hDEADBE12)); // 11
    vq.push_back(mk(1'b1, 1'b0, 1'b1, 3'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0));      // 12 wr RO
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 3'd0, 32'h0,        4'h0, 1'b0, 32'h0));      // 13 rd SYS_ID
    vq.push_back(mk(1'b1, 1'b1, 1'b1, 3'd3, 32'h11111111, 4'hF, 1'b1, SID));        // 14 rd+wr
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 3'd3, 32'h0,        4'h0, 1'b1, 32'hDEADBE12)); // 15 rd scratch
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        4'h0, 1'b0, 32'h0));      // 16 reset drops it
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 3'd3, 32'h0,        4'h0, 1'b0, 32'h0));      // 17 rd scratch
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 3'd7, 32'h0,        4'h0, 1'b1, SRST));       // 18 rd CONTROL
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 32'h0));      // 19
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        4'h0, 1'b0, 32'h0));      // 20
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 3'd0, 32'h0,        4'h0, 1'b0, 32'h0));      // 21 rd
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        4'h0, 1'b0, 32'h0));      // 22 reset next cycle
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        4'h0, 1'b0, 32'h0));      // 23
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        4'h0, 1'b0, 32'h0));      // 24

    foreach (vq[i]) begin
      reset_n = vq[i].rstn; read = vq[i].rd; write = vq[i].wr; address = vq[i].addr;
      writedata = vq[i].wd; byteenable = vq[i].be;
      step();
      chk($sformatf("row%0d_vld", i), {31'd0, rdv0}, {31'd0, vq[i].exp_vld});
      chk($sformatf("row%0d_dat", i), readdata0, vq[i].exp_dat);
      chk($sformatf("row%0d_tick", i), {31'd0, tick0}, 32'd0);
    end
    idle_bus();

    // Tick cadence with TICK_DIV=4 over 400 cycles after reset.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    prev = 1'b0; cnt = 0; first = -1; last = -1; width_err = 0; space_err = 0;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (tick1 && prev) width_err++;
      if (tick1 && !prev) begin
        cnt++;
        if (last >= 0 && (i - last) != 4) space_err++;
        if (first < 0) first = i;
        last = i;
      end
      prev = tick1;
    end
    chk("tick_count", 32'(cnt), 32'd100);
    chk("tick_first", 32'(first), 32'd4);
    chk("tick_width_err", 32'(width_err), 32'd0);
    chk("tick_space_err", 32'(space_err), 32'd0);
    read = 1'b1; address = 3'd4;
    step();
    read = 1'b0;
    chk("uptime_lo_vld", {31'd0, rdv1}, 32'd1);
    chk("uptime_lo_100", readdata1, 32'd100);

    // Low-word read on the carry cycle into the high word.
    force dut1.prescaler_q = 24'd3;
    force dut1.uptime_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut1.prescaler_q;
    release dut1.uptime_q;
    read = 1'b1; address = 3'd4;
    step();
    chk("carry_lo", readdata1, 32'hFFFF_FFFF);
    chk("carry_tick", {31'd0, tick1}, 32'd1);
    address = 3'd5;
    step();
    chk("carry_hi", readdata1, 32'h0);
    address = 3'd4;
    step();
    chk("after_lo", readdata1, 32'h0);
    address = 3'd5;
    step();
    chk("after_hi", readdata1, 32'h1);
    chk("after_hi_vld", {31'd0, rdv1}, 32'd1);
    read = 1'b0;

    // CONTROL clear on the wrap cycle: clear wins, no tick, prescaler restarts.
    force dut1.prescaler_q = 24'd3;
    force dut1.uptime_q = 64'h0000_0007_0000_0009;
    #1;
    release dut1.prescaler_q;
    release dut1.uptime_q;
    write = 1'b1; address = 3'd7; writedata = 32'h1; byteenable = 4'h1;
    step();
    idle_bus();
    chk("clr_no_tick", {31'd0, tick1}, 32'd0);
    read = 1'b1; address = 3'd4;
    step();
    chk("clr_lo", readdata1, 32'h0);
    address = 3'd5;
    step();
    chk("clr_hi", readdata1, 32'h0);
    read = 1'b0;
    step();
    chk("clr_tick_pre", {31'd0, tick1}, 32'd0);
    step();
    chk("clr_tick_4th", {31'd0, tick1}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
